// File: rtl/shifter32.sv
// shifter32: registered 32-bit barrel shifter, one result per cycle, 1-cycle latency.
//
// Ports:
//   clk        in   single clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset, clears dout and out_valid
//   in_valid   in   qualifies din/shamt/LR/AL in the current cycle
//   din        in   [31:0] data to shift
//   shamt      in   [4:0] unsigned shift amount 0..31
//   LR         in   direction: 1 = left, 0 = right
//   AL         in   right-shift kind: 1 = arithmetic, 0 = logical (ignored for left)
//   out_valid  out  high when dout holds a result produced on the previous edge
//   dout       out  [31:0] registered shift result, held while no new operation arrives
//
// The shift is a 5-level logarithmic network: level k moves the word by 2^k
// positions when shamt[k] is set. Left and right chains are built separately
// and selected at the end, so every level is a fixed-width 2:1 mux.
module shifter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] din,
    input  logic [4:0]  shamt,
    input  logic        LR,
    input  logic        AL,
    output logic        out_valid,
    output logic [31:0] dout
);

    // Stage 0 is the raw input; stage 5 is the fully shifted word.
    logic [31:0] lstage [6];
    logic [31:0] rstage [6];

    // Bit shifted into vacated high positions on a right shift.
    logic        fill;

    logic [31:0] dout_d;
    logic [31:0] dout_q;
    logic        out_valid_q;

    assign fill      = AL & din[31];
    assign lstage[0] = din;
    assign rstage[0] = din;

    for (genvar k = 0; k < 5; k++) begin : g_level
        localparam int Sh = 1 << k;

        // Left: drop the top Sh bits, zero-fill the bottom.
        assign lstage[k+1] = shamt[k] ? {lstage[k][31-Sh:0], {Sh{1'b0}}} : lstage[k];

        // Right: drop the bottom Sh bits, fill the top with zero or the sign.
        assign rstage[k+1] = shamt[k] ? {{Sh{fill}}, rstage[k][31:Sh]} : rstage[k];
    end

    always_comb begin
        dout_d = dout_q;
        if (in_valid) begin
            dout_d = LR ? lstage[5] : rstage[5];
        end
    end

    // out_valid follows only in_valid, so X on the data inputs while idle
    // never reaches it, and dout keeps its value when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q      <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            out_valid_q <= in_valid;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shifter32.sv
module tb_shifter32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic        LR;
    logic        AL;
    logic        out_valid;
    logic [31:0] dout;

    int n_checks;
    int n_fail;

    shifter32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din       (din),
        .shamt     (shamt),
        .LR        (LR),
        .AL        (AL),
        .out_valid (out_valid),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample 1 time unit
    // after the following rising edge.
    task automatic step(input logic r, input logic v, input logic [31:0] d,
                        input logic [4:0] s, input logic lr, input logic al);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        din      = d;
        shamt    = s;
        LR       = lr;
        AL       = al;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] exp_d, input logic exp_v);
        check({tag, "_dout"}, dout, exp_d);
        check({tag, "_vld"}, {31'd0, out_valid}, {31'd0, exp_v});
    endtask

    logic [31:0] rd;
    logic [4:0]  rs;
    logic        rlr;
    logic        ral;
    logic [31:0] rexp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        shamt    = '0;
        LR       = 1'b0;
        AL       = 1'b0;

        // Reset for two cycles, with an operation offered that must be discarded.
        step(1'b0, 1'b1, 32'hAAAA_AAAA, 5'd2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h1234_5678, 5'd4, 1'b1, 1'b0);
        expect_out("reset", 32'h0000_0000, 1'b0);

        // Idle after reset with X data: out_valid must stay low.
        step(1'b1, 1'b0, 32'hxxxx_xxxx, 5'bxxxxx, 1'bx, 1'bx);
        expect_out("idle0", 32'h0000_0000, 1'b0);

        step(1'b1, 1'b1, 32'hAAAA_AAAA, 5'd2, 1'b1, 1'b0);
        expect_out("sll2", 32'hAAAA_AAA8, 1'b1);
        step(1'b1, 1'b1, 32'hAAAA_AAAA, 5'd2, 1'b0, 1'b0);
        expect_out("srl2", 32'h2AAA_AAAA, 1'b1);
        step(1'b1, 1'b1, 32'hFFFF_FFFA, 5'd2, 1'b0, 1'b1);
        expect_out("sra2", 32'hFFFF_FFFE, 1'b1);
        step(1'b1, 1'b1, 32'hFFFF_FFFA, 5'd2, 1'b0, 1'b0);
        expect_out("srl2n", 32'h3FFF_FFFE, 1'b1);

        step(1'b1, 1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b1);
        expect_out("sra31", 32'hFFFF_FFFF, 1'b1);
        step(1'b1, 1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        expect_out("srl31", 32'h0000_0001, 1'b1);
        step(1'b1, 1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b0);
        expect_out("sll31", 32'h0000_0000, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0001, 5'd31, 1'b1, 1'b1);
        expect_out("sll31b", 32'h8000_0000, 1'b1);

        step(1'b1, 1'b1, 32'h8000_0000, 5'd0, 1'b1, 1'b0);
        expect_out("s0_l0", 32'h8000_0000, 1'b1);
        step(1'b1, 1'b1, 32'h8000_0000, 5'd0, 1'b1, 1'b1);
        expect_out("s0_l1", 32'h8000_0000, 1'b1);
        step(1'b1, 1'b1, 32'h8000_0000, 5'd0, 1'b0, 1'b0);
        expect_out("s0_r0", 32'h8000_0000, 1'b1);
        step(1'b1, 1'b1, 32'h8000_0000, 5'd0, 1'b0, 1'b1);
        expect_out("s0_r1", 32'h8000_0000, 1'b1);

        step(1'b1, 1'b1, 32'h1234_5678, 5'd4, 1'b1, 1'b0);
        expect_out("sll4", 32'h2345_6780, 1'b1);
        step(1'b1, 1'b1, 32'h8765_4321, 5'd16, 1'b0, 1'b0);
        expect_out("srl16", 32'h0000_8765, 1'b1);
        step(1'b1, 1'b1, 32'h8765_4321, 5'd8, 1'b0, 1'b1);
        expect_out("sra8", 32'hFF87_6543, 1'b1);
        step(1'b1, 1'b1, 32'h4765_4321, 5'd8, 1'b0, 1'b1);
        expect_out("sra8pos", 32'h0047_6543, 1'b1);
        step(1'b1, 1'b1, 32'h0000_000F, 5'd1, 1'b1, 1'b1);
        expect_out("sll1_al", 32'h0000_001E, 1'b1);

        // Back-to-back stream, then idle with dout held.
        step(1'b1, 1'b1, 32'h0000_FFFF, 5'd8, 1'b1, 1'b0);
        expect_out("b2b0", 32'h00FF_FF00, 1'b1);
        step(1'b1, 1'b1, 32'hF000_0000, 5'd4, 1'b0, 1'b1);
        expect_out("b2b1", 32'hFF00_0000, 1'b1);
        step(1'b1, 1'b1, 32'hF000_0000, 5'd4, 1'b0, 1'b0);
        expect_out("b2b2", 32'h0F00_0000, 1'b1);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0, 1'b0);
        expect_out("b2b3", 32'h6F56_DF77, 1'b1);
        step(1'b1, 1'b0, 32'hxxxx_xxxx, 5'bxxxxx, 1'bx, 1'bx);
        expect_out("hold1", 32'h6F56_DF77, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0000, 5'd3, 1'b1, 1'b0);
        expect_out("hold2", 32'h6F56_DF77, 1'b0);

        // Reset mid-stream together with a valid op.
        step(1'b1, 1'b1, 32'h0000_0003, 5'd1, 1'b1, 1'b0);
        expect_out("pre_rst", 32'h0000_0006, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0003, 5'd2, 1'b1, 1'b0);
        expect_out("mid_rst", 32'h0000_0000, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0003, 5'd2, 1'b1, 1'b0);
        expect_out("post_rst", 32'h0000_0000, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0003, 5'd2, 1'b1, 1'b0);
        expect_out("first_op", 32'h0000_000C, 1'b1);

        // Random sweep against a behavioural reference.
        for (int i = 0; i < 10000; i++) begin
            rd  = $urandom;
            rs  = 5'($urandom_range(0, 31));
            rlr = 1'($urandom_range(0, 1));
            ral = 1'($urandom_range(0, 1));
            if (rlr) rexp = rd << rs;
            else if (ral) rexp = $unsigned($signed(rd) >>> rs);
            else rexp = rd >> rs;
            step(1'b1, 1'b1, rd, rs, rlr, ral);
            check("rand_dout", dout, rexp);
        end
        step(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        expect_out("rand_end", rexp, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
